// File: rtl/bmp280_calib_loader.sv
// Purpose: mode-0 SPI master that reads the BMP280 chip ID and 24-byte trim block, then unpacks it into twelve 32-bit words.
// Latency: about 2*CLK_DIV*216 clk per load, plus CSN setup/hold/gap; all dig_* outputs update together in one cycle.
// Backpressure: none; start is ignored while busy, and outputs hold their values until the next load completes.
module bmp280_calib_loader #(
  parameter int         CLK_DIV    = 25,
  parameter logic [7:0] CHIP_ID    = 8'h58,
  parameter bit         AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        spi_miso,
  output logic        spi_sck,
  output logic        spi_csn,
  output logic        spi_mosi,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] dig_t1,
  output logic [31:0] dig_t2,
  output logic [31:0] dig_t3,
  output logic [31:0] dig_p1,
  output logic [31:0] dig_p2,
  output logic [31:0] dig_p3,
  output logic [31:0] dig_p4,
  output logic [31:0] dig_p5,
  output logic [31:0] dig_p6,
  output logic [31:0] dig_p7,
  output logic [31:0] dig_p8,
  output logic [31:0] dig_p9
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(2 * CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] GAP_MIN  = HW'(2 * CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE, S_ID_XFER, S_ID_CHK, S_GAP, S_CAL_XFER, S_UNPACK, S_DONE, S_ERR
  } state_t;

  // Bit-level phase of the SPI engine: WAIT = CSN high, LOW/HIGH = SCK halves, HOLD = CSN hold after last fall.
  typedef enum logic [1:0] {P_WAIT, P_LOW, P_HIGH, P_HOLD} phase_t;

  state_t        r_state, w_next;
  phase_t        r_ph;
  logic [DW-1:0] r_div;
  logic [HW-1:0] r_hi;        // cycles CSN has been high, saturating at GAP_MIN
  logic [2:0]    r_bit;
  logic [4:0]    r_byte;      // 0 = address byte, 1..N = data bytes
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic [7:0]    r_id;
  logic [7:0]    r_shadow [24];
  logic          r_sck, r_csn, r_mosi;
  logic          r_auto;
  logic [31:0]   r_dig [12];

  logic          w_in_xfer, w_launch, w_div_end, w_xfer_end, w_byte_end;
  logic [7:0]    w_addr;
  logic [4:0]    w_last_byte;

  function automatic logic [31:0] zext16(input logic [7:0] hi, input logic [7:0] lo);
    return {16'h0000, hi, lo};
  endfunction

  function automatic logic [31:0] sext16(input logic [7:0] hi, input logic [7:0] lo);
    return {{16{hi[7]}}, hi, lo};
  endfunction

  assign w_in_xfer   = (r_state == S_ID_XFER) || (r_state == S_CAL_XFER);
  assign w_launch    = w_in_xfer && (r_ph == P_WAIT) && (r_hi == GAP_MIN);
  assign w_div_end   = (r_div == DIV_LAST);
  assign w_xfer_end  = (r_ph == P_HOLD) && w_div_end;
  assign w_byte_end  = (r_ph == P_HIGH) && w_div_end && (r_bit == 3'd7);
  assign w_addr      = (r_state == S_ID_XFER) ? 8'hD0 : 8'h88;
  assign w_last_byte = (r_state == S_ID_XFER) ? 5'd1 : 5'd24;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and status decode.
  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    error  = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start || r_auto) w_next = S_ID_XFER;
      end
      S_ID_XFER:  if (w_xfer_end) w_next = S_ID_CHK;
      S_ID_CHK:   w_next = (r_id == CHIP_ID) ? S_GAP : S_ERR;
      S_GAP:      if (r_hi == GAP_MIN) w_next = S_CAL_XFER;
      S_CAL_XFER: if (w_xfer_end) w_next = S_UNPACK;
      S_UNPACK:   w_next = S_DONE;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) w_next = S_ID_XFER;
      end
      S_ERR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (start) w_next = S_ID_XFER;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // SPI engine: CSN/SCK/MOSI generation, bit and byte counting, MISO shift-in on SCK rise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ph   <= P_WAIT;
      r_div  <= '0;
      r_hi   <= '0;
      r_bit  <= '0;
      r_byte <= '0;
      r_tx   <= '0;
      r_rx   <= '0;
      r_sck  <= 1'b0;
      r_csn  <= 1'b1;
      r_mosi <= 1'b0;
      r_auto <= AUTO_START;
    end else begin
      r_auto <= 1'b0;
      if (r_csn && (r_hi != GAP_MIN)) r_hi <= r_hi + HW'(1);
      case (r_ph)
        P_WAIT: begin
          if (w_launch) begin
            r_csn  <= 1'b0;
            r_mosi <= w_addr[7];
            r_tx   <= {w_addr[6:0], 1'b0};
            r_div  <= '0;
            r_bit  <= '0;
            r_byte <= '0;
            r_ph   <= P_LOW;
          end
        end
        P_LOW: begin
          if (w_div_end) begin
            r_div <= '0;
            r_sck <= 1'b1;
            r_rx  <= {r_rx[6:0], spi_miso};
            r_ph  <= P_HIGH;
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        P_HIGH: begin
          if (w_div_end) begin
            r_div <= '0;
            r_sck <= 1'b0;
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_mosi <= 1'b0;
              if (r_byte == w_last_byte) begin
                r_ph <= P_HOLD;
              end else begin
                r_byte <= r_byte + 5'd1;
                r_ph   <= P_LOW;
              end
            end else begin
              // Only the address byte carries data on MOSI; data bytes send zeros.
              r_mosi <= (r_byte == 5'd0) ? r_tx[7] : 1'b0;
              r_tx   <= {r_tx[6:0], 1'b0};
              r_ph   <= P_LOW;
            end
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        P_HOLD: begin
          if (w_div_end) begin
            r_div <= '0;
            r_csn <= 1'b1;
            r_hi  <= '0;
            r_ph  <= P_WAIT;
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        default: r_ph <= P_WAIT;
      endcase
    end
  end

  // Chip-ID capture at the end of the single ID data byte.
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_id <= '0;
    else if (w_byte_end && (r_byte != 5'd0) && (r_state == S_ID_XFER))
      r_id <= r_rx;
  end

  // Trim shadow: data byte k of the calibration burst lands in r_shadow[k].
  always_ff @(posedge clk) begin
    if (w_byte_end && (r_byte != 5'd0) && (r_state == S_CAL_XFER))
      r_shadow[r_byte - 5'd1] <= r_rx;
  end

  // Little-endian unpack; all twelve words update in the same cycle so readers never see a mixed set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 12; i++) r_dig[i] <= '0;
    end else if (r_state == S_UNPACK) begin
      r_dig[0]  <= zext16(r_shadow[1],  r_shadow[0]);
      r_dig[1]  <= sext16(r_shadow[3],  r_shadow[2]);
      r_dig[2]  <= sext16(r_shadow[5],  r_shadow[4]);
      r_dig[3]  <= zext16(r_shadow[7],  r_shadow[6]);
      r_dig[4]  <= sext16(r_shadow[9],  r_shadow[8]);
      r_dig[5]  <= sext16(r_shadow[11], r_shadow[10]);
      r_dig[6]  <= sext16(r_shadow[13], r_shadow[12]);
      r_dig[7]  <= sext16(r_shadow[15], r_shadow[14]);
      r_dig[8]  <= sext16(r_shadow[17], r_shadow[16]);
      r_dig[9]  <= sext16(r_shadow[19], r_shadow[18]);
      r_dig[10] <= sext16(r_shadow[21], r_shadow[20]);
      r_dig[11] <= sext16(r_shadow[23], r_shadow[22]);
    end
  end

  assign spi_sck  = r_sck;
  assign spi_csn  = r_csn;
  assign spi_mosi = r_mosi;
  assign dig_t1   = r_dig[0];
  assign dig_t2   = r_dig[1];
  assign dig_t3   = r_dig[2];
  assign dig_p1   = r_dig[3];
  assign dig_p2   = r_dig[4];
  assign dig_p3   = r_dig[5];
  assign dig_p4   = r_dig[6];
  assign dig_p5   = r_dig[7];
  assign dig_p6   = r_dig[8];
  assign dig_p7   = r_dig[9];
  assign dig_p8   = r_dig[10];
  assign dig_p9   = r_dig[11];

endmodule
